// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the MEM stage and a variable-latency
// memory using a req/ack handshake. It holds the pipeline while an access is
// outstanding, merges that stall with the Hazard_Unit controls, and aborts
// hung accesses with a saturating watchdog.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   MemReadM, MemWriteM      load / store present in MEM stage
//   ALUOutM, WriteDataM      access address / store data
//   HazStallF/D, HazFlushE   Hazard_Unit controls to be merged
//   mem_ack, mem_rdata       memory completion pulse and read data
//   mem_req, mem_we          registered request and write enable
//   mem_addr, mem_wdata      registered address and write data
//   ReadDataM                load result (valid in DONE, else 0)
//   StallF/D/E/M, FlushE/W   final per-stage pipeline controls
//   MemErr                   one-cycle watchdog timeout pulse
module dmem_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  HazStallF,
    input  logic                  HazStallD,
    input  logic                  HazFlushE,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic access_c;
    logic memstall_c;

    assign access_c   = MemReadM | MemWriteM;
    assign memstall_c = ((state_q == S_IDLE) & access_c) | (state_q == S_WAIT);

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;   // read+write together is a write
                    addr_d  = ALUOutM;
                    wdata_d = WriteDataM;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // Ack takes priority over a coincident timeout
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                    req_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                // Single cycle so IDLE always sees the next MEM instruction
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign MemErr    = err_q;
    assign ReadDataM = (state_q == S_DONE) ? rdata_q : '0;

    // EX holds instead of flushing during a memory stall; the hazard
    // condition is re-evaluated once the stall releases.
    assign StallF = HazStallF | memstall_c;
    assign StallD = HazStallD | memstall_c;
    assign StallE = memstall_c;
    assign StallM = memstall_c;
    assign FlushE = HazFlushE & ~memstall_c;
    assign FlushW = memstall_c;

endmodule
